// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared stage widths, control-bit indices and stage-buffer state encoding
package pipe_pkg;

  localparam int IF_ID_CTRL_W  = 4;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 8;
  localparam int ID_EX_DATA_W  = 128;
  localparam int EX_MEM_CTRL_W = 5;
  localparam int EX_MEM_DATA_W = 106;
  localparam int MEM_WB_CTRL_W = 2;
  localparam int MEM_WB_DATA_W = 69;

  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMTOREG  = 1;
  localparam int CTRL_MEMREAD   = 2;
  localparam int CTRL_MEMWRITE  = 3;
  localparam int CTRL_ALUOP_LSB = 4;
  localparam int CTRL_ALUOP_W   = 2;
  localparam int CTRL_ALUSRC    = 6;

  // Encoding doubles as the entry count, so occupancy is the state register itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  function automatic logic [1:0] state_occupancy(input buf_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - saturating accumulator, sticks at all-ones
module pipe_sat_cnt #(
  parameter int CNT_W = 16,
  parameter int INC_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W:0] sum;

  assign sum = {1'b0, cnt_o} + {{(CNT_W + 1 - INC_W){1'b0}}, inc_i};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - ready/valid pipeline stage register with 2-entry skid, flush and stall
// Optional counters enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  buf_state_e        state;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;
  logic              accept, fire;

  assign in_ready_o  = (state != ST_TWO) && !stall_i;
  assign out_valid_o = (state != ST_EMPTY) && !stall_i;
  assign accept      = in_valid_i && in_ready_o;
  assign fire        = out_valid_o && out_ready_i;

  // Bubbles must never leak RegWrite/MemWrite downstream; payload is left as-is.
  assign ctrl_o      = out_valid_o ? m_ctrl : '0;
  assign data_o      = m_data;
  assign occupancy_o = state_occupancy(state);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= ST_EMPTY;
      m_ctrl <= '0;
      m_data <= '0;
      s_ctrl <= '0;
      s_data <= '0;
    end else if (flush_i) begin
      state <= ST_EMPTY;
    end else if (!stall_i) begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            state  <= ST_ONE;
            m_ctrl <= ctrl_i;
            m_data <= data_i;
          end
        end
        ST_ONE: begin
          if (accept && fire) begin
            m_ctrl <= ctrl_i;
            m_data <= data_i;
          end else if (accept) begin
            state  <= ST_TWO;
            s_ctrl <= ctrl_i;
            s_data <= data_i;
          end else if (fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (fire) begin
            state  <= ST_ONE;
            m_ctrl <= s_ctrl;
            m_data <= s_data;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_cnt #(.CNT_W(CNT_W), .INC_W(2)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stall_i && !flush_i),
    .inc_i (2'd1),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W), .INC_W(2)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (flush_i),
    .inc_i (occupancy_o),
    .cnt_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic, parametrised pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Successor to fixed-field stage latches: same register-and-hold role, plus ready/valid handshake, a 2-entry skid buffer, flush/bubble insertion and a stall input.
- Control bits and datapath payload are carried separately, so a bubble can zero only the control bits.

Parameters:
- CTRL_W, 8: width of control bundle (RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc, ...).
- DATA_W, 128: width of payload bundle (operands, register addresses, funct, immediate).
- CNT_W, 16: width of performance counters (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-low reset.
- in_valid_i  in  1  upstream has a valid entry.
- in_ready_o  out  1  stage can accept an entry this cycle.
- ctrl_i  in  CTRL_W  upstream control bundle.
- data_i  in  DATA_W  upstream payload.
- stall_i  in  1  global hold, e.g. data-memory stall.
- flush_i  in  1  discard all held entries.
- out_valid_o  out  1  output entry valid.
- out_ready_i  in  1  downstream accepts.
- ctrl_o  out  CTRL_W  control bundle; all-zero when out_valid_o=0.
- data_o  out  DATA_W  payload; don't-care when out_valid_o=0.
- occupancy_o  out  2  number of entries held (0..2).
- stall_cnt_o  out  CNT_W  stall cycles counted (only with PIPE_STAGE_PERF_EN).
- flush_cnt_o  out  CNT_W  flushed entries counted (only with PIPE_STAGE_PERF_EN).

Behaviour:
- Reset: rst_i sampled low at a rising edge gives state EMPTY.
  - All registers zero; out_valid_o=0; ctrl_o=0; data_o=0; occupancy_o=0; counters=0.
  - in_ready_o=1 from the first cycle after reset.
  - A reset in mid-operation drops held entries without any output transfer.
- Transfers:
  - Accept = in_valid_i & in_ready_o.
  - Fire = out_valid_o & out_ready_i.
  - Both are evaluated on the same edge.
- Storage: main register M drives the outputs; skid register S.
- States and transitions:
  - EMPTY: accept → ONE, M←in.
  - ONE:
    - accept & fire → ONE, M←in.
    - accept only → TWO, S←in.
    - fire only → EMPTY.
  - TWO: in_ready_o=0.
    - fire → ONE, M←S.
    - otherwise hold.
- in_ready_o = (state≠TWO) & ~stall_i. It is combinational on stall_i only.
- out_valid_o = (state≠EMPTY) & ~stall_i, so there are no transfers on either side while stalled.
- ctrl_o = M.ctrl when out_valid_o=1, else 0. This is the bubble guarantee: no spurious RegWrite or MemWrite downstream.
- Stall: stall_i=1 holds all state registers unchanged. M/S contents are preserved across any stall length.
- Flush: flush_i=1 → next state EMPTY. flush_i has priority over stall_i, accept and fire.
  - The same-cycle input is discarded, not accepted. in_ready_o is still driven as above, but the entry is dropped.
- Latency:
  - 1 cycle from accept to out_valid_o when in EMPTY, or when in ONE with a simultaneous fire.
  - Sustained throughput is 1 entry/cycle.
- Order: strictly FIFO. M always holds the older entry.
- occupancy_o encodes EMPTY=0, ONE=1, TWO=2 and is registered.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt_o increments on every cycle with stall_i=1 & ~flush_i.
  - flush_cnt_o adds occupancy (0..2) on every flush.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both ports still exist and are tied to 0; no counter logic.

Decomposition:
- Shared package pipe_pkg:
  - Per-stage CTRL_W/DATA_W constants (ID_EX_CTRL_W=8, ID_EX_DATA_W=128, ...).
  - Control-bit index constants (CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3, CTRL_ALUOP_LSB=4, CTRL_ALUSRC=6).
  - State encoding constants (ST_EMPTY, ST_ONE, ST_TWO).
- Sub-module: pipe_sat_cnt (saturating counter, CNT_W), instantiated twice under the macro.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with in_valid_i=1 → out_valid_o=0, ctrl_o=0, occupancy_o=0; in_ready_o=1 in the first cycle after release.
- Streaming: out_ready_i=1, push ctrl 0x0F/data A, then 0x01/B, then 0x08/C on consecutive cycles → same sequence on the outputs one cycle later; occupancy_o stays ≤1.
- Backpressure: out_ready_i=0, push A, B, C → A, B accepted, in_ready_o=0 with occupancy_o=2, C held upstream; release out_ready_i → A, B, C delivered in order.
- Stall: occupancy 2, stall_i=1 for 5 cycles → out_valid_o=0, ctrl_o=0, in_ready_o=0; entries A, B intact after release; stall_cnt_o=5 (macro on).
- Flush priority: occupancy 2, flush_i=1 & stall_i=1 & in_valid_i=1 → next cycle occupancy_o=0, ctrl_o=0, input discarded; flush_cnt_o=2 (macro on).
- Simultaneous accept/fire in ONE: in_valid_i=1, out_ready_i=1 for 10 cycles → occupancy_o stays 1; all 10 entries emerge in order with 1-cycle latency.
